uart_lsu_ctrl: RTL

Memory-mapped controller that shares the UART between the pipelined processor's load/store unit and the serial link. It buffers outbound bytes in a small TX FIFO, feeds them to the UART transmitter with a start/busy/done handshake, and latches inbound bytes in a one-entry RX holding register. It stalls the pipeline only when the LSU stores to a full TX FIFO.

---
 rtl/uart_lsu_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/uart_lsu_ctrl.sv
// uart_lsu_ctrl: LSU-mapped UART front end with TX FIFO, TX handshake FSM and RX holding register.
// Rev 1.0
`default_nettype none

module uart_lsu_ctrl #(
  parameter int TX_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [1:0]  lsu_addr_i,
  input  logic [7:0]  lsu_wdata_i,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_ack_o,
  output logic        pipe_en_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_start_o,
  input  logic        tx_busy_i,
  input  logic        tx_done_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_done_i,
  output logic        Ff_o,
  output logic        Fe_o,
  output logic        Rxff_o
);

  localparam int AW = $clog2(TX_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [1:0] ADDR_TX     = 2'd0;
  localparam logic [1:0] ADDR_RX     = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      mem_q [TX_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      tx_data_q;
  logic            load_tx;
  logic            rxff_q, rxff_d, ovr_q, ovr_d;
  logic [7:0]      rx_buf_q, rx_buf_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            ack_q;

  logic full, empty, tx_store, stall, accept, push, pop, rd_rx, rd_st;

  assign full     = (count_q == CW'(TX_DEPTH));
  assign empty    = (count_q == '0);
  assign tx_store = lsu_req_i & lsu_we_i & (lsu_addr_i == ADDR_TX);
  // A full FIFO is judged on registered count only, so a same-cycle pop never admits the push.
  assign stall    = tx_store & full;
  assign accept   = lsu_req_i & ~stall;
  assign push     = tx_store & ~full;
  assign pop      = (state_q == START);
  assign rd_rx    = lsu_req_i & ~lsu_we_i & (lsu_addr_i == ADDR_RX);
  assign rd_st    = lsu_req_i & ~lsu_we_i & (lsu_addr_i == ADDR_STATUS);

  always_comb begin
    state_d = state_q;
    load_tx = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && !tx_busy_i) begin
          state_d = START;
          load_tx = 1'b1;
        end
      end
      START:   state_d = WAIT;
      WAIT:    if (tx_done_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Overrun wins over the STATUS clear; a clearing RXDATA read makes room for a coincident byte.
  always_comb begin
    rxff_d   = rxff_q;
    ovr_d    = ovr_q;
    rx_buf_d = rx_buf_q;
    if (rd_st) ovr_d = 1'b0;
    if (rd_rx) rxff_d = 1'b0;
    if (rx_done_i) begin
      if (!rxff_q || rd_rx) begin
        rx_buf_d = rx_data_i;
        rxff_d   = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_comb begin
    rdata_d = '0;
    if (accept && !lsu_we_i) begin
      case (lsu_addr_i)
        ADDR_RX:     rdata_d = rxff_q ? {24'b0, rx_buf_q} : 32'b0;
        ADDR_STATUS: rdata_d = {28'b0, ovr_q, rxff_q, full, empty};
        default:     rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= lsu_wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      tx_data_q <= '0;
      rxff_q    <= 1'b0;
      ovr_q     <= 1'b0;
      rx_buf_q  <= '0;
      rdata_q   <= '0;
      ack_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rxff_q   <= rxff_d;
      ovr_q    <= ovr_d;
      rx_buf_q <= rx_buf_d;
      rdata_q  <= rdata_d;
      ack_q    <= accept;
      if (push)    wr_ptr_q  <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q  <= rd_ptr_q + AW'(1);
      if (load_tx) tx_data_q <= mem_q[rd_ptr_q];
    end
  end

  assign lsu_rdata_o = rdata_q;
  assign lsu_ack_o   = ack_q;
  assign pipe_en_o   = ~stall;
  assign tx_data_o   = tx_data_q;
  assign tx_start_o  = (state_q == START);
  assign Ff_o        = full;
  assign Fe_o        = empty;
  assign Rxff_o      = rxff_q;

endmodule

`default_nettype wire
